// File: rtl/per2axi_res_channel_buf.sv
// per2axi_res_channel_buf
// Buffered AXI R/B -> peripheral response channel. R and B are arbitrated
// round-robin into a small FIFO. R data is narrowed to the 32-bit lane
// recorded for its ID at request time. The redundant B of an atomic
// transaction is swallowed by a per-ID tracker.
module per2axi_res_channel_buf #(
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      per_slave_r_valid_o,
    input  logic                      per_slave_r_ready_i,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,
    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,
    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,
    input  logic                      atop_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   atop_id_i,
    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i
);

    localparam int NLANES = AXI_DATA_WIDTH / 32;
    localparam int LANE_W = $clog2(NLANES);
    localparam int LW     = (LANE_W == 0) ? 1 : LANE_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        AT_NONE    = 2'd0,
        AT_REQUEST = 2'd1,
        AT_WAIT_R  = 2'd2,
        AT_WAIT_B  = 2'd3
    } atop_state_t;

    typedef struct packed {
        logic                    opc;
        logic [PER_ID_WIDTH-1:0] id;
        logic [31:0]             data;
    } rsp_t;

    function automatic logic [PER_ID_WIDTH-1:0] id_onehot(input logic [AXI_ID_WIDTH-1:0] id);
        id_onehot = '0;
        for (int k = 0; k < PER_ID_WIDTH; k++) begin
            if (int'(id) == k) id_onehot[k] = 1'b1;
        end
    endfunction

    function automatic logic id_ok(input logic [AXI_ID_WIDTH-1:0] id);
        id_ok = (int'(id) < PER_ID_WIDTH);
    endfunction

    // Write status encoding: OKAY->1, EXOKAY->0, SLVERR->2, DECERR->3.
    function automatic logic [31:0] b_status(input logic [1:0] resp);
        b_status = {30'b0, resp[1], ~(resp[1] ^ resp[0])};
    endfunction

    logic [LW-1:0]     lane_tbl_q [PER_ID_WIDTH];
    atop_state_t       atop_state_q [PER_ID_WIDTH];
    atop_state_t       atop_state_d [PER_ID_WIDTH];
    logic              prio_r_q;
    rsp_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              empty, full, push, pop, space;
    logic              b_supp, b_drop, grant_r, grant_b;
    logic              r_cand, b_cand, atop_tgt_busy;
    logic [LW-1:0]     lane_new, lane_r;
    logic [31:0]       r_lane_data;
    rsp_t              push_data, head;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop      = !empty && per_slave_r_ready_i;
    assign push     = grant_r || grant_b;
    assign lane_new = (LANE_W == 0) ? '0 : LW'(trans_add_i >> 2);
    assign head     = mem_q[rd_ptr_q];

    // Look up the lane for the R beat and its ATOP state for the B response.
    always_comb begin
        lane_r        = '0;
        b_supp        = 1'b0;
        atop_tgt_busy = 1'b0;
        for (int k = 0; k < PER_ID_WIDTH; k++) begin
            if (int'(axi_master_r_id_i) == k) lane_r = lane_tbl_q[k];
            if (int'(axi_master_b_id_i) == k && atop_state_q[k] != AT_NONE) b_supp = 1'b1;
            if (int'(atop_id_i) == k && atop_state_q[k] != AT_NONE) atop_tgt_busy = 1'b1;
        end
    end

    // Select the 32-bit lane of the R data beat.
    always_comb begin
        r_lane_data = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (int'(lane_r) == k) r_lane_data = axi_master_r_data_i[32*k +: 32];
        end
    end

    // Round-robin grant. A suppressed B bypasses arbitration entirely: it needs
    // no FIFO slot, so it is drained alongside any R grant and leaves priority alone.
    always_comb begin
        space   = !full || pop;
        r_cand  = axi_master_r_valid_i;
        b_cand  = axi_master_b_valid_i && !b_supp;
        grant_r = 1'b0;
        grant_b = 1'b0;
        if (!rst_i && space) begin
            if (r_cand && (prio_r_q || !b_cand)) grant_r = 1'b1;
            else if (b_cand)                     grant_b = 1'b1;
        end
        b_drop = !rst_i && axi_master_b_valid_i && b_supp;
    end

    assign axi_master_r_ready_o = grant_r;
    assign axi_master_b_ready_o = grant_b || b_drop;

    // Build the FIFO entry for whichever channel was granted.
    always_comb begin
        push_data.opc  = grant_r ? axi_master_r_resp_i[1] : axi_master_b_resp_i[1];
        push_data.id   = grant_r ? id_onehot(axi_master_r_id_i) : id_onehot(axi_master_b_id_i);
        push_data.data = grant_r ? r_lane_data : b_status(axi_master_b_resp_i);
    end

    // Per-ID ATOP tracker next state; the B of an ATOP never reaches the FIFO.
    always_comb begin
        for (int k = 0; k < PER_ID_WIDTH; k++) begin
            logic r_hs, b_hs;
            atop_state_d[k] = atop_state_q[k];
            r_hs = grant_r && (int'(axi_master_r_id_i) == k);
            b_hs = (grant_b || b_drop) && (int'(axi_master_b_id_i) == k);
            case (atop_state_q[k])
                AT_NONE: begin
                    if (atop_req_i && int'(atop_id_i) == k) atop_state_d[k] = AT_REQUEST;
                end
                AT_REQUEST: begin
                    if (r_hs && b_hs) atop_state_d[k] = AT_NONE;
                    else if (r_hs)    atop_state_d[k] = AT_WAIT_B;
                    else if (b_hs)    atop_state_d[k] = AT_WAIT_R;
                end
                AT_WAIT_R: if (r_hs) atop_state_d[k] = AT_NONE;
                AT_WAIT_B: if (b_hs) atop_state_d[k] = AT_NONE;
                default:   atop_state_d[k] = AT_NONE;
            endcase
        end
    end

    // Control state: ATOP trackers, lane table, priority and FIFO pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < PER_ID_WIDTH; k++) begin
                atop_state_q[k] <= AT_NONE;
                lane_tbl_q[k]   <= '0;
            end
            prio_r_q <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int k = 0; k < PER_ID_WIDTH; k++) begin
                atop_state_q[k] <= atop_state_d[k];
                if (trans_req_i && int'(trans_id_i) == k) lane_tbl_q[k] <= lane_new;
            end
            if (grant_r)      prio_r_q <= 1'b0;
            else if (grant_b) prio_r_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Head of FIFO drives the peripheral side; zero whenever nothing is queued.
    always_comb begin
        per_slave_r_valid_o = !empty;
        per_slave_r_opc_o   = 1'b0;
        per_slave_r_id_o    = '0;
        per_slave_r_rdata_o = '0;
        if (!empty) begin
            per_slave_r_opc_o   = head.opc;
            per_slave_r_id_o    = head.id;
            per_slave_r_rdata_o = head.data;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                           axi_master_r_resp_i[0], trans_add_i};

    a_atop_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        atop_req_i |-> (id_ok(atop_id_i) && !atop_tgt_busy));
    a_r_id_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_master_r_valid_i |-> id_ok(axi_master_r_id_i));
    a_b_id_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        axi_master_b_valid_i |-> id_ok(axi_master_b_id_i));

endmodule

// File: tb/tb_per2axi_res_channel_buf.sv
// Directed bench for per2axi_res_channel_buf with a 128-bit AXI data path.
module tb_per2axi_res_channel_buf;

    localparam int PER_ID_WIDTH   = 5;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 128;
    localparam int AXI_ID_WIDTH   = 3;
    localparam int AXI_USER_WIDTH = 6;
    localparam int FIFO_DEPTH     = 4;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      per_slave_r_valid_o;
    logic                      per_slave_r_ready_i;
    logic                      per_slave_r_opc_o;
    logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o;
    logic [31:0]               per_slave_r_rdata_o;
    logic                      axi_master_r_valid_i;
    logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i;
    logic [1:0]                axi_master_r_resp_i;
    logic                      axi_master_r_last_i;
    logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i;
    logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i;
    logic                      axi_master_r_ready_o;
    logic                      axi_master_b_valid_i;
    logic [1:0]                axi_master_b_resp_i;
    logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i;
    logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i;
    logic                      axi_master_b_ready_o;
    logic                      atop_req_i;
    logic [AXI_ID_WIDTH-1:0]   atop_id_i;
    logic                      trans_req_i;
    logic [AXI_ID_WIDTH-1:0]   trans_id_i;
    logic [AXI_ADDR_WIDTH-1:0] trans_add_i;

    int n_cmp = 0;
    int n_err = 0;

    per2axi_res_channel_buf #(
        .PER_ID_WIDTH  (PER_ID_WIDTH),
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .AXI_ID_WIDTH  (AXI_ID_WIDTH),
        .AXI_USER_WIDTH(AXI_USER_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .per_slave_r_valid_o (per_slave_r_valid_o),
        .per_slave_r_ready_i (per_slave_r_ready_i),
        .per_slave_r_opc_o   (per_slave_r_opc_o),
        .per_slave_r_id_o    (per_slave_r_id_o),
        .per_slave_r_rdata_o (per_slave_r_rdata_o),
        .axi_master_r_valid_i(axi_master_r_valid_i),
        .axi_master_r_data_i (axi_master_r_data_i),
        .axi_master_r_resp_i (axi_master_r_resp_i),
        .axi_master_r_last_i (axi_master_r_last_i),
        .axi_master_r_id_i   (axi_master_r_id_i),
        .axi_master_r_user_i (axi_master_r_user_i),
        .axi_master_r_ready_o(axi_master_r_ready_o),
        .axi_master_b_valid_i(axi_master_b_valid_i),
        .axi_master_b_resp_i (axi_master_b_resp_i),
        .axi_master_b_id_i   (axi_master_b_id_i),
        .axi_master_b_user_i (axi_master_b_user_i),
        .axi_master_b_ready_o(axi_master_b_ready_o),
        .atop_req_i          (atop_req_i),
        .atop_id_i           (atop_id_i),
        .trans_req_i         (trans_req_i),
        .trans_id_i          (trans_id_i),
        .trans_add_i         (trans_add_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] id, input logic [31:0] data,
                           input logic opc);
        chk({tag, ".valid"}, 64'(per_slave_r_valid_o), 64'd1);
        chk({tag, ".id"},    64'(per_slave_r_id_o),    64'(id));
        chk({tag, ".rdata"}, 64'(per_slave_r_rdata_o), 64'(data));
        chk({tag, ".opc"},   64'(per_slave_r_opc_o),   64'(opc));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [127:0] d128;
    logic [1:0]   b_resp_tbl [3];
    logic [31:0]  b_data_tbl [3];
    logic         b_opc_tbl  [3];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d128 = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        b_resp_tbl[0] = 2'b10; b_data_tbl[0] = 32'd2; b_opc_tbl[0] = 1'b1;
        b_resp_tbl[1] = 2'b01; b_data_tbl[1] = 32'd0; b_opc_tbl[1] = 1'b0;
        b_resp_tbl[2] = 2'b11; b_data_tbl[2] = 32'd3; b_opc_tbl[2] = 1'b1;

        rst_i = 1'b1;
        per_slave_r_ready_i  = 1'b1;
        axi_master_r_valid_i = 1'b1;
        axi_master_r_data_i  = '0;
        axi_master_r_resp_i  = '0;
        axi_master_r_last_i  = 1'b0;
        axi_master_r_id_i    = '0;
        axi_master_r_user_i  = '0;
        axi_master_b_valid_i = 1'b1;
        axi_master_b_resp_i  = '0;
        axi_master_b_id_i    = '0;
        axi_master_b_user_i  = '0;
        atop_req_i  = 1'b0;
        atop_id_i   = '0;
        trans_req_i = 1'b0;
        trans_id_i  = '0;
        trans_add_i = '0;

        // Reset: everything quiet even with both AXI channels valid.
        #2;
        chk("rst.valid", 64'(per_slave_r_valid_o), 64'd0);
        chk("rst.r_ready", 64'(axi_master_r_ready_o), 64'd0);
        chk("rst.b_ready", 64'(axi_master_b_ready_o), 64'd0);
        chk("rst.rdata", 64'(per_slave_r_rdata_o), 64'd0);
        chk("rst.id", 64'(per_slave_r_id_o), 64'd0);
        tick();
        rst_i = 1'b0;
        axi_master_r_valid_i = 1'b0;
        axi_master_b_valid_i = 1'b0;
        tick();

        // Round-robin: R id1 and B id3 always valid, grants alternate R,B,R,B.
        axi_master_r_id_i    = 3'd1;
        axi_master_r_data_i  = {96'b0, 32'h1111_1111};
        axi_master_b_id_i    = 3'd3;
        axi_master_b_resp_i  = 2'b00;
        axi_master_r_valid_i = 1'b1;
        axi_master_b_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb.r_ready", 64'(axi_master_r_ready_o), 64'((i % 2) == 0));
            chk("arb.b_ready", 64'(axi_master_b_ready_o), 64'((i % 2) == 1));
            tick();
            if ((i % 2) == 0) chk_out("arb.r", 5'b00010, 32'h1111_1111, 1'b0);
            else              chk_out("arb.b", 5'b01000, 32'd1, 1'b0);
        end
        axi_master_r_valid_i = 1'b0;
        axi_master_b_valid_i = 1'b0;
        tick();
        chk("arb.drain", 64'(per_slave_r_valid_o), 64'd0);

        // Lane select: id2 at 0x0C -> lane 3; same-cycle re-request uses old lane.
        trans_req_i = 1'b1;
        trans_id_i  = 3'd2;
        trans_add_i = 32'h0000_000C;
        tick();
        trans_req_i = 1'b0;
        axi_master_r_valid_i = 1'b1;
        axi_master_r_id_i    = 3'd2;
        axi_master_r_data_i  = d128;
        axi_master_r_resp_i  = 2'b00;
        #1;
        chk("lane.r_ready", 64'(axi_master_r_ready_o), 64'd1);
        tick();
        chk_out("lane.d3", 5'b00100, 32'hDDDD_0003, 1'b0);
        trans_req_i = 1'b1;
        trans_add_i = 32'h0000_0004;
        tick();
        chk_out("lane.old", 5'b00100, 32'hDDDD_0003, 1'b0);
        trans_req_i = 1'b0;
        axi_master_r_resp_i = 2'b10;
        tick();
        chk_out("lane.d1", 5'b00100, 32'hDDDD_0001, 1'b1);
        axi_master_r_valid_i = 1'b0;
        axi_master_r_resp_i  = 2'b00;
        tick();
        chk("lane.drain", 64'(per_slave_r_valid_o), 64'd0);

        // ATOP id0: B first is swallowed, then R is forwarded.
        atop_req_i = 1'b1;
        atop_id_i  = 3'd0;
        tick();
        atop_req_i = 1'b0;
        chk("atop.req", 64'(dut.atop_state_q[0]), 64'd1);
        axi_master_b_valid_i = 1'b1;
        axi_master_b_id_i    = 3'd0;
        #1;
        chk("atop.b_ready", 64'(axi_master_b_ready_o), 64'd1);
        tick();
        axi_master_b_valid_i = 1'b0;
        chk("atop.b_swallowed", 64'(per_slave_r_valid_o), 64'd0);
        chk("atop.wait_r", 64'(dut.atop_state_q[0]), 64'd2);
        axi_master_r_valid_i = 1'b1;
        axi_master_r_id_i    = 3'd0;
        #1;
        chk("atop.r_ready", 64'(axi_master_r_ready_o), 64'd1);
        tick();
        axi_master_r_valid_i = 1'b0;
        chk_out("atop.r", 5'b00001, 32'hDDDD_0000, 1'b0);
        chk("atop.none", 64'(dut.atop_state_q[0]), 64'd0);
        tick();
        chk("atop.drain", 64'(per_slave_r_valid_o), 64'd0);

        // ATOP id0 again with R and B in the same cycle.
        atop_req_i = 1'b1;
        tick();
        atop_req_i = 1'b0;
        axi_master_r_valid_i = 1'b1;
        axi_master_b_valid_i = 1'b1;
        #1;
        chk("atop2.r_ready", 64'(axi_master_r_ready_o), 64'd1);
        chk("atop2.b_ready", 64'(axi_master_b_ready_o), 64'd1);
        tick();
        axi_master_r_valid_i = 1'b0;
        axi_master_b_valid_i = 1'b0;
        chk("atop2.none", 64'(dut.atop_state_q[0]), 64'd0);
        chk_out("atop2.r", 5'b00001, 32'hDDDD_0000, 1'b0);
        tick();
        chk("atop2.single", 64'(per_slave_r_valid_o), 64'd0);

        // Backpressure: 4 beats fill the FIFO, the 5th waits for the first pop.
        per_slave_r_ready_i  = 1'b0;
        axi_master_r_valid_i = 1'b1;
        axi_master_r_id_i    = 3'd1;
        for (int c = 0; c < 4; c++) begin
            axi_master_r_data_i = 128'(32'hB000_0000 + c);
            #1;
            chk("bp.fill_ready", 64'(axi_master_r_ready_o), 64'd1);
            tick();
        end
        axi_master_r_data_i = 128'(32'hB000_0004);
        #1;
        chk("bp.full_ready", 64'(axi_master_r_ready_o), 64'd0);
        tick();
        chk("bp.still_full", 64'(axi_master_r_ready_o), 64'd0);
        chk_out("bp.head", 5'b00010, 32'hB000_0000, 1'b0);
        per_slave_r_ready_i = 1'b1;
        #1;
        chk("bp.pop_ready", 64'(axi_master_r_ready_o), 64'd1);
        tick();
        axi_master_r_valid_i = 1'b0;
        for (int c = 1; c < 5; c++) begin
            chk_out("bp.order", 5'b00010, 32'hB000_0000 + 32'(c), 1'b0);
            tick();
        end
        chk("bp.drain", 64'(per_slave_r_valid_o), 64'd0);

        // B response encodings on id4.
        axi_master_b_id_i = 3'd4;
        for (int i = 0; i < 3; i++) begin
            axi_master_b_valid_i = 1'b1;
            axi_master_b_resp_i  = b_resp_tbl[i];
            #1;
            chk("bresp.ready", 64'(axi_master_b_ready_o), 64'd1);
            tick();
            axi_master_b_valid_i = 1'b0;
            chk_out("bresp", 5'b10000, b_data_tbl[i], b_opc_tbl[i]);
            tick();
        end
        axi_master_b_resp_i = 2'b00;

        // Reset with 3 queued entries and id1 in WAIT_B.
        per_slave_r_ready_i = 1'b0;
        atop_req_i = 1'b1;
        atop_id_i  = 3'd1;
        tick();
        atop_req_i = 1'b0;
        axi_master_r_valid_i = 1'b1;
        axi_master_r_id_i    = 3'd1;
        axi_master_r_data_i  = d128;
        #1;
        chk("mrst.r_ready", 64'(axi_master_r_ready_o), 64'd1);
        tick();
        chk("mrst.wait_b", 64'(dut.atop_state_q[1]), 64'd3);
        axi_master_r_id_i = 3'd2;
        tick();
        tick();
        axi_master_r_valid_i = 1'b0;
        chk_out("mrst.head", 5'b00010, 32'hDDDD_0000, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("mrst.valid", 64'(per_slave_r_valid_o), 64'd0);
        chk("mrst.fsm", 64'(dut.atop_state_q[1]), 64'd0);
        tick();
        rst_i = 1'b0;
        per_slave_r_ready_i  = 1'b1;
        axi_master_b_valid_i = 1'b1;
        axi_master_b_id_i    = 3'd1;
        #1;
        chk("mrst.b_ready", 64'(axi_master_b_ready_o), 64'd1);
        tick();
        axi_master_b_valid_i = 1'b0;
        chk_out("mrst.b_fwd", 5'b00010, 32'd1, 1'b0);
        tick();
        chk("mrst.empty", 64'(per_slave_r_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
